// File: rtl/register_file_mp_if.sv
// Bus bundle for the multi-port register file: three read ports, two write
// ports, the reservation request and the pending scoreboard view.
interface register_file_mp_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 4
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [ADDR_W-1:0] rd_addr3;
  logic [N-1:0]      rd_data1;
  logic [N-1:0]      rd_data2;
  logic [N-1:0]      rd_data3;
  logic              rd_ready1;
  logic              rd_ready2;
  logic              rd_ready3;

  logic              wr_en0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [N-1:0]      wr_data0;
  logic              wr_en1;
  logic [ADDR_W-1:0] wr_addr1;
  logic [N-1:0]      wr_data1;

  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ok;
  logic [DEPTH-1:0]  pending;

  modport master (
    output rd_addr1, rd_addr2, rd_addr3,
    input  rd_data1, rd_data2, rd_data3,
    input  rd_ready1, rd_ready2, rd_ready3,
    output wr_en0, wr_addr0, wr_data0,
    output wr_en1, wr_addr1, wr_data1,
    output rsv_en, rsv_addr,
    input  rsv_ok, pending
  );

  modport slave (
    input  rd_addr1, rd_addr2, rd_addr3,
    output rd_data1, rd_data2, rd_data3,
    output rd_ready1, rd_ready2, rd_ready3,
    input  wr_en0, wr_addr0, wr_data0,
    input  wr_en1, wr_addr1, wr_data1,
    input  rsv_en, rsv_addr,
    output rsv_ok, pending
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: 3 combinational read ports, 2 write ports
// (port 1 outranks port 0), optional same-cycle write-to-read bypass and a
// per-register pending scoreboard used by decode to stall on load operands.
module register_file_mp #(
  parameter int N           = 32,
  parameter int ADDR_W      = 4,
  parameter int RESET_INDEX = 1,
  parameter int BYPASS      = 1
) (
  input  logic               clk,
  input  logic               rst,
  register_file_mp_if.slave  rf
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [N-1:0]     regs_q [DEPTH];
  logic [N-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Write enables are masked while reset is held so that in-flight writes
  // neither bypass to readers nor disturb the scoreboard view.
  logic             wr_en0_s;
  logic             wr_en1_s;
  logic [DEPTH-1:0] wr0_hit_s;
  logic [DEPTH-1:0] wr1_hit_s;
  logic             rsv_ok_s;
  logic             rsv_acc_s;
  logic [N:0]       rd1_s;
  logic [N:0]       rd2_s;
  logic [N:0]       rd3_s;

  // Read-port view: {ready, data}. Port 1 outranks port 0 on bypass.
  function automatic logic [N:0] read_port(
    input logic [ADDR_W-1:0] a,
    input logic [N-1:0]      stored,
    input logic              pend,
    input logic              en0,
    input logic [ADDR_W-1:0] a0,
    input logic [N-1:0]      d0,
    input logic              en1,
    input logic [ADDR_W-1:0] a1,
    input logic [N-1:0]      d1
  );
    logic       hit0;
    logic       hit1;
    logic [N-1:0] data;
    logic       rdy;
    hit0 = (BYPASS != 0) && en0 && (a0 == a);
    hit1 = (BYPASS != 0) && en1 && (a1 == a);
    if (hit1) begin
      data = d1;
    end else if (hit0) begin
      data = d0;
    end else begin
      data = stored;
    end
    rdy = !pend || hit0 || hit1;
    return {rdy, data};
  endfunction

  assign wr_en0_s = rf.wr_en0 & rst;
  assign wr_en1_s = rf.wr_en1 & rst;

  // Decode each write port into a per-register hit vector.
  always_comb begin
    wr0_hit_s = '0;
    wr1_hit_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr0_hit_s[i] = wr_en0_s && (rf.wr_addr0 == ADDR_W'(i));
      wr1_hit_s[i] = wr_en1_s && (rf.wr_addr1 == ADDR_W'(i));
    end
  end

  // A reservation is accepted when the target is free or is being written now.
  always_comb begin
    rsv_ok_s  = !pending_q[rf.rsv_addr]
                || (wr_en0_s && (rf.wr_addr0 == rf.rsv_addr))
                || (wr_en1_s && (rf.wr_addr1 == rf.rsv_addr));
    rsv_acc_s = rf.rsv_en && rsv_ok_s;
  end

  // Next register contents: port 1 data wins over port 0 on a collision.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr1_hit_s[i]) begin
        regs_d[i] = rf.wr_data1;
      end else if (wr0_hit_s[i]) begin
        regs_d[i] = rf.wr_data0;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Next scoreboard: a fresh reservation outranks the clear from a write.
  always_comb begin
    pending_d = pending_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (rsv_acc_s && (rf.rsv_addr == ADDR_W'(i))) begin
        pending_d[i] = 1'b1;
      end else if (wr0_hit_s[i] || wr1_hit_s[i]) begin
        pending_d[i] = 1'b0;
      end else begin
        pending_d[i] = pending_q[i];
      end
    end
  end

  // Register array and scoreboard state; reset loads index or zero values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (RESET_INDEX != 0) ? N'(i) : {N{1'b0}};
      end
      pending_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q <= pending_d;
    end
  end

  // Combinational read ports with optional bypass and operand-ready flag.
  always_comb begin
    rd1_s = read_port(rf.rd_addr1, regs_q[rf.rd_addr1], pending_q[rf.rd_addr1],
                      wr_en0_s, rf.wr_addr0, rf.wr_data0,
                      wr_en1_s, rf.wr_addr1, rf.wr_data1);
    rd2_s = read_port(rf.rd_addr2, regs_q[rf.rd_addr2], pending_q[rf.rd_addr2],
                      wr_en0_s, rf.wr_addr0, rf.wr_data0,
                      wr_en1_s, rf.wr_addr1, rf.wr_data1);
    rd3_s = read_port(rf.rd_addr3, regs_q[rf.rd_addr3], pending_q[rf.rd_addr3],
                      wr_en0_s, rf.wr_addr0, rf.wr_data0,
                      wr_en1_s, rf.wr_addr1, rf.wr_data1);
  end

  assign rf.rd_data1  = rd1_s[N-1:0];
  assign rf.rd_ready1 = rd1_s[N];
  assign rf.rd_data2  = rd2_s[N-1:0];
  assign rf.rd_ready2 = rd2_s[N];
  assign rf.rd_data3  = rd3_s[N-1:0];
  assign rf.rd_ready3 = rd3_s[N];
  assign rf.rsv_ok    = rsv_ok_s;
  assign rf.pending   = pending_q;

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port general-purpose register file; successor to the 16x32 single-write register file in the core datapath.
- Generalised width and depth, with 3 read ports and 2 write ports (ALU result + load/base writeback).
- Adds same-cycle write-to-read bypass and a per-register pending scoreboard, so decode can stall on operands from outstanding loads.

Parameters:
- N, 32, data width in bits.
- ADDR_W, 4, register address width; DEPTH = 2**ADDR_W registers.
- RESET_INDEX, 1: 1 = register i resets to value i (zero-extended to N); 0 = all registers reset to 0.
- BYPASS, 1: 1 = reads see same-cycle write data; 0 = reads see stored contents only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low: asserted when 0, released when 1.
- rd_addr1, rd_addr2, rd_addr3  in  ADDR_W each  read addresses.
- rd_data1, rd_data2, rd_data3  out  N each  read data, combinational.
- rd_ready1, rd_ready2, rd_ready3  out  1 each  operand valid (not pending, or being written this cycle).
- wr_en0  in  1  write port 0 enable.
- wr_addr0  in  ADDR_W  write port 0 address.
- wr_data0  in  N  write port 0 data.
- wr_en1  in  1  write port 1 enable; port 1 has priority over port 0.
- wr_addr1  in  ADDR_W  write port 1 address.
- wr_data1  in  N  write port 1 data.
- rsv_en  in  1  reserve request: mark rsv_addr pending.
- rsv_addr  in  ADDR_W  register to reserve.
- rsv_ok  out  1  reserve can be accepted this cycle.
- pending  out  DEPTH  pending bit per register, registered.

Behaviour:
- Reset (rst=0, asynchronous): reg[i] = RESET_INDEX ? i : 0 for all i; pending = 0. Read outputs reflect reset contents immediately. All other inputs are ignored while in reset.
- A write or reservation in flight when reset asserts is discarded.
- Writes: on a rising clk edge, wr_enK=1 stores wr_dataK into reg[wr_addrK]. Write latency is 1 cycle.
- Both ports writing the same address: port 1 data is stored; port 0 is dropped.
- Reads: rd_dataX = reg[rd_addrX], combinational, zero-cycle latency.
- Bypass (BYPASS=1): if wr_enK=1 and wr_addrK == rd_addrX, rd_dataX = wr_dataK (port 1 wins when both match). With BYPASS=0, the new value is visible from the next cycle.
- Scoreboard: at a rising edge, pending[a] becomes:
  - 1 if a reservation of a is accepted this cycle;
  - else 0 if either write port targets a;
  - else unchanged.
- rsv_ok = !pending[rsv_addr] || (wr_en0 && wr_addr0==rsv_addr) || (wr_en1 && wr_addr1==rsv_addr).
- A reservation is accepted only when rsv_en && rsv_ok. If rsv_en=1 and rsv_ok=0, there is no state change; the requester must hold the request and retry.
- Reserve and write to the same address in the same cycle: the data is stored and pending ends at 1 (new reservation outranks the clear).
- rd_readyX = !pending[rd_addrX] || (BYPASS && a write port targets rd_addrX this cycle).
- With BYPASS=0: rd_readyX = !pending[rd_addrX].
- Writes to a non-pending register are legal and leave pending at 0.
- Addresses wrap naturally within ADDR_W bits; no out-of-range case exists.
- pending is a registered output; changes appear after the rising edge.

Test Plan:
- Reset: drive rst=0 mid-cycle with N=32, ADDR_W=4 -> immediately rd_data1(addr 5)=5, rd_data2(addr 15)=15, pending=16'h0000; after release, contents are unchanged until the first write.
- Dual-write collision: wr_en0=1 addr 3 data 32'hAAAA_0000 and wr_en1=1 addr 3 data 32'h5555_1111 in the same cycle -> next cycle reg3 = 32'h5555_1111. In that same cycle, rd_addr1=3 bypasses 32'h5555_1111.
- Bypass: write 32'hDEAD_BEEF to r7 while rd_addr2=7 -> rd_data2 = 32'hDEAD_BEEF in the same cycle. Repeat with BYPASS=0 -> old value in the same cycle, new value the next cycle.
- Scoreboard: rsv_en addr 9 -> next cycle pending[9]=1, rsv_ok=0 for addr 9, rd_ready1(addr 9)=0.
  - wr_en1 addr 9 data 32'h42 -> rd_ready1=1 in the write cycle with rd_data1=32'h42; pending[9]=0 after the edge.
- Reserve + write same cycle: r4 pending, wr_en0 addr 4 data 1, plus rsv_en addr 4 -> rsv_ok=1, reg4=1, pending[4] stays 1.
- Reset mid-operation: r2 pending and a write to r2 in flight when rst drops -> pending=0, reg2=2 (RESET_INDEX=1), and the write is discarded.
